countdown_timer: RTL
====================

// Module: countdown_timer
// PURPOSE
//   Countdown counterpart of the up-counting stopwatch. Counts 6 BCD digits (hh:mm:ss) from a loaded preset down to 00:00:00 at one step per second.
//   Raises done/alarm on expiry. Output digit layout is identical to the up-timer, so the same 7-seg display path consumes `out`.
// PARAMETERS
//   TICK_DIV  50_000_000  clk cycles per 1 s decrement (50 MHz board); benches use 4
//   PS_W      $clog2(TICK_DIV)  prescaler width (derived, localparam)
// PORTS
//   clk          in   1   system clock
//   rst          in   1   reset, asynchronous, active-low
//   key_start_n  in   1   start/pause key, active-low level, debounced externally
//   key_load_n   in   1   load-preset key, active-low level, debounced externally
//   preset       in   24  BCD hh:mm:ss; [23:20] h10, [19:16] h1, [15:12] m10, [11:8] m1, [7:4] s10, [3:0] s1
//   out          out  24  current BCD count, same layout as preset
//   running      out  1   1 while state==RUN
//   done         out  1   1-cycle pulse when count reaches 00:00:00
//   alarm        out  1   level, 1 while state==EXPIRED
//   err          out  1   1-cycle pulse on rejected (invalid) preset load
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, out=0, prescaler=0, running/done/alarm/err=0, key sync flops=1 (released).
//   Key path: each key -> 2-flop synchronizer -> falling-edge detect (prev=1 & now=0).
//     Latency: key low before clk edge k -> registered effect visible after edge k+2. Holding a key low acts only once.
//   Preset valid iff all digits <=9 and s10<=5 and m10<=5. Valid range is 00:00:00..99:59:59.
//   States: IDLE, PAUSED, RUN, EXPIRED.
//   Load edge, accepted in IDLE/PAUSED/EXPIRED:
//     valid preset:   out<=preset, prescaler<=0, alarm cleared.
//                     next state = PAUSED if preset!=0, else IDLE.
//     invalid preset: out unchanged, state unchanged, err pulses 1 cycle.
//     In RUN:         load is ignored (no err).
//   Start edge:
//     PAUSED -> RUN.
//     RUN -> PAUSED; prescaler holds its value so the paused fraction of a second resumes.
//     IDLE/EXPIRED: ignored.
//   Simultaneous load+start edges in the same cycle: load wins, start dropped.
//   RUN: prescaler increments every clk.
//     At TICK_DIV-1: prescaler wraps to 0 and out decrements by one second, same edge.
//     First decrement comes TICK_DIV cycles after RUN entry from prescaler=0.
//   Decrement (BCD borrow chain, all digits updated same edge):
//     s1: 0->9 borrow, else -1; s10: 0->5 borrow; m1: 0->9 borrow; m10: 0->5 borrow; h1: 0->9 borrow; h10: -1.
//     out never decrements below 0.
//   Expiry: the tick that makes out==0 also sets state=EXPIRED, done=1 for that one cycle, alarm=1, running=0.
//     EXPIRED holds out=0 until a load or reset.
//   done/err are registered pulses, exactly 1 cycle wide. running/alarm are registered from the next state (no extra lag).
//   Reset mid-operation overrides everything immediately, regardless of state.
// TESTING (TICK_DIV=4)
//   1. Reset: rst=0 -> out=24'h000000, running=0, done=0, alarm=0, err=0. Holds with keys idle.
//   2. preset=24'h000003, load, start -> out steps 000002, 000001, 000000, 4 clk apart.
//      At 000000: done high exactly 1 cycle, alarm=1, running=0. Further start edges ignored.
//   3. preset=24'h100000, load, start -> first tick out=24'h095959.
//      preset=24'h000100 -> first tick out=24'h000059.
//   4. Pause: start edge mid-second (prescaler=2) -> out frozen >=100 cycles.
//      Start again -> next decrement after exactly 2 more cycles.
//   5. Invalid preset 24'h006000 and 24'h00000A -> err 1-cycle pulse, out/state unchanged.
//      Load during RUN -> ignored. preset=0 load -> IDLE, start ignored.
//   6. Load+start same cycle in PAUSED -> new preset loaded, stays PAUSED.
//      Async rst pulse during RUN -> out=0, IDLE, without waiting for clk.

Source files
------------

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_timer
//  Purpose  : Six-digit BCD countdown timer (hh:mm:ss). Loads a preset,
//             counts down one second per TICK_DIV clocks while running, and
//             signals expiry with a one-cycle done pulse plus an alarm level.
//             Output digit layout matches the up-counting stopwatch so the
//             same 7-segment display path can consume `out`.
//  Ports    : clk          system clock
//             rst          asynchronous reset, active-low
//             key_start_n  start/pause key, active-low level (debounced)
//             key_load_n   load-preset key, active-low level (debounced)
//             preset[23:0] BCD h10,h1,m10,m1,s10,s1 (MSB to LSB)
//             out[23:0]    current BCD count, same layout as preset
//             running      1 while counting
//             done         1-cycle pulse when the count reaches 00:00:00
//             alarm        1 while expired
//             err          1-cycle pulse on a rejected (invalid) load
//  Revision : 1.0  initial release
// ============================================================================
module countdown_timer #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_start_n,
    input  logic        key_load_n,
    input  logic [23:0] preset,
    output logic [23:0] out,
    output logic        running,
    output logic        done,
    output logic        alarm,
    output logic        err
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] C_PS_LAST = PS_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAUSED  = 2'd1,
        RUN     = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [23:0]       out_q, out_d;
    logic [PS_W-1:0]   ps_q, ps_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              alarm_q, alarm_d;
    logic              err_q, err_d;

    // Key synchronizers (s1, s2) plus a delayed copy for falling-edge detect.
    logic start_s1_q, start_s2_q, start_prev_q;
    logic load_s1_q, load_s2_q, load_prev_q;
    logic start_edge, load_edge;

    assign start_edge = start_prev_q & ~start_s2_q;
    assign load_edge  = load_prev_q  & ~load_s2_q;

    // All digits <= 9, tens of minutes and seconds <= 5.
    function automatic logic preset_valid(input logic [23:0] v);
        preset_valid = (v[23:20] <= 4'd9) && (v[19:16] <= 4'd9) &&
                       (v[15:12] <= 4'd5) && (v[11:8]  <= 4'd9) &&
                       (v[7:4]   <= 4'd5) && (v[3:0]   <= 4'd9);
    endfunction

    // One-second BCD decrement; each digit borrows from the next one up.
    // Callers guarantee v != 0.
    function automatic logic [23:0] bcd_dec(input logic [23:0] v);
        logic [23:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    // Tens-of-seconds and tens-of-minutes wrap to 5, others to 9.
                    r[i*4 +: 4] = ((i == 1) || (i == 3)) ? 4'd5 : 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        bcd_dec = r;
    endfunction

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        ps_d    = ps_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (load_edge && (state_q != RUN)) begin
            // A load edge consumes the cycle: a coincident start edge is dropped.
            if (preset_valid(preset)) begin
                out_d   = preset;
                ps_d    = '0;
                state_d = (preset != 24'h0) ? PAUSED : IDLE;
            end else begin
                err_d = 1'b1;
            end
        end else if (start_edge && (state_q == PAUSED)) begin
            state_d = RUN;
        end else if (start_edge && (state_q == RUN)) begin
            // Prescaler is left alone so the partial second resumes later.
            state_d = PAUSED;
        end else if (state_q == RUN) begin
            if (ps_q == C_PS_LAST) begin
                ps_d = '0;
                if (out_q != 24'h0) begin
                    out_d = bcd_dec(out_q);
                    if (bcd_dec(out_q) == 24'h0) begin
                        state_d = EXPIRED;
                        done_d  = 1'b1;
                    end
                end
            end else begin
                ps_d = ps_q + PS_W'(1);
            end
        end

        running_d = (state_d == RUN);
        alarm_d   = (state_d == EXPIRED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            out_q        <= 24'h0;
            ps_q         <= '0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            alarm_q      <= 1'b0;
            err_q        <= 1'b0;
            start_s1_q   <= 1'b1;
            start_s2_q   <= 1'b1;
            start_prev_q <= 1'b1;
            load_s1_q    <= 1'b1;
            load_s2_q    <= 1'b1;
            load_prev_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            ps_q         <= ps_d;
            running_q    <= running_d;
            done_q       <= done_d;
            alarm_q      <= alarm_d;
            err_q        <= err_d;
            start_s1_q   <= key_start_n;
            start_s2_q   <= start_s1_q;
            start_prev_q <= start_s2_q;
            load_s1_q    <= key_load_n;
            load_s2_q    <= load_s1_q;
            load_prev_q  <= load_s2_q;
        end
    end

    assign out     = out_q;
    assign running = running_q;
    assign done    = done_q;
    assign alarm   = alarm_q;
    assign err     = err_q;

endmodule
`default_nettype wire
